// File: rtl/spi_word_rx.sv
// SPI slave receive front end: synchronises SCLK/CS_N/MOSI into clk,
// assembles serial bits into WORD_WIDTH-bit words, and flags truncated words.
module spi_word_rx #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned MSB_FIRST   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_enable,
    input  logic                          spi_sclk,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic [WORD_WIDTH-1:0]         rx_data,
    output logic                          rx_data_valid,
    output logic                          frame_abort,
    output logic                          cs_active,
    output logic [$clog2(WORD_WIDTH)-1:0] bit_count
);

    localparam int unsigned CNT_W      = $clog2(WORD_WIDTH);
    localparam logic        IDLE_SCLK  = 1'(CPOL);
    // Leading edge samples when CPHA=0; rising is leading when CPOL=0.
    localparam logic        SAMPLE_LVL = (CPOL == CPHA) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_active_q, cs_active_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       bit_count_q, bit_count_d;
    logic [WORD_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_data_valid_q, rx_data_valid_d;
    logic                   frame_abort_q, frame_abort_d;

    logic                   sclk_s, cs_n_s, mosi_s;
    logic                   sample, last_bit, cs_rise, cs_fall;
    logic [WORD_WIDTH-1:0]  shift_in;

    // Synchroniser chains for the three asynchronous SPI pins.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_n_s      = cs_n_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_d      = sclk_s;
    end

    // Edge detection and qualification; cs_active_q is the previous-cycle CS.
    always_comb begin
        sample   = (sclk_s != sclk_q) && (sclk_s == SAMPLE_LVL) &&
                   cs_active_q && rx_enable;
        last_bit = (bit_count_q == LAST_BIT);
        cs_rise  = cs_n_s && cs_active_q;
        cs_fall  = !cs_n_s && !cs_active_q;
        if (MSB_FIRST != 0) begin
            shift_in = {shift_q[WORD_WIDTH-2:0], mosi_s};
        end else begin
            shift_in = {mosi_s, shift_q[WORD_WIDTH-1:1]};
        end
    end

    // Word assembly, completion and abort decisions.
    always_comb begin
        shift_d         = shift_q;
        bit_count_d     = bit_count_q;
        rx_data_d       = rx_data_q;
        rx_data_valid_d = 1'b0;
        frame_abort_d   = 1'b0;
        cs_active_d     = !cs_n_s;

        if (!rx_enable) begin
            shift_d     = '0;
            bit_count_d = '0;
        end else begin
            if (sample) begin
                if (last_bit) begin
                    rx_data_d       = shift_in;
                    rx_data_valid_d = 1'b1;
                    shift_d         = '0;
                    bit_count_d     = '0;
                end else begin
                    shift_d     = shift_in;
                    bit_count_d = bit_count_q + CNT_W'(1);
                end
            end
            // A word completing in the same cycle as CS rising is kept.
            if (cs_rise && !(sample && last_bit)) begin
                frame_abort_d = sample || (bit_count_q != '0);
                shift_d       = '0;
                bit_count_d   = '0;
            end else if (cs_fall) begin
                shift_d     = '0;
                bit_count_d = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q     <= {SYNC_STAGES{IDLE_SCLK}};
            cs_n_sync_q     <= {SYNC_STAGES{1'b1}};
            mosi_sync_q     <= '0;
            sclk_q          <= IDLE_SCLK;
            cs_active_q     <= 1'b0;
            shift_q         <= '0;
            bit_count_q     <= '0;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
            frame_abort_q   <= 1'b0;
        end else begin
            sclk_sync_q     <= sclk_sync_d;
            cs_n_sync_q     <= cs_n_sync_d;
            mosi_sync_q     <= mosi_sync_d;
            sclk_q          <= sclk_d;
            cs_active_q     <= cs_active_d;
            shift_q         <= shift_d;
            bit_count_q     <= bit_count_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
            frame_abort_q   <= frame_abort_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;
    assign frame_abort   = frame_abort_q;
    assign cs_active     = cs_active_q;
    assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_spi_word_rx.sv
// Scoreboard bench for spi_word_rx across four SPI mode / bit-order builds.
module tb_spi_word_rx;

    typedef struct packed {
        logic [1:0]  idx;
        logic        abort;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk [4];
    logic        cs_n [4];
    logic        mosi [4];
    logic        en   [4];
    logic [31:0] rxd  [4];
    logic        vld  [4];
    logic        abt  [4];
    logic        csa  [4];
    logic [4:0]  bc   [4];

    // Instance configs: 0 mode0/MSB, 1 mode3/MSB, 2 mode1/MSB, 3 mode0/LSB.
    int cpol_c [4] = '{0, 1, 0, 0};
    int cpha_c [4] = '{0, 1, 1, 0};

    exp_t exp_q [$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    spi_word_rx #(.WORD_WIDTH(32), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .rx_enable(en[0]), .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]),
        .spi_mosi(mosi[0]), .rx_data(rxd[0]), .rx_data_valid(vld[0]),
        .frame_abort(abt[0]), .cs_active(csa[0]), .bit_count(bc[0]));
    spi_word_rx #(.WORD_WIDTH(32), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .rx_enable(en[1]), .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]),
        .spi_mosi(mosi[1]), .rx_data(rxd[1]), .rx_data_valid(vld[1]),
        .frame_abort(abt[1]), .cs_active(csa[1]), .bit_count(bc[1]));
    spi_word_rx #(.WORD_WIDTH(32), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .rx_enable(en[2]), .spi_sclk(sclk[2]), .spi_cs_n(cs_n[2]),
        .spi_mosi(mosi[2]), .rx_data(rxd[2]), .rx_data_valid(vld[2]),
        .frame_abort(abt[2]), .cs_active(csa[2]), .bit_count(bc[2]));
    spi_word_rx #(.WORD_WIDTH(32), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u3 (
        .clk(clk), .rst(rst), .rx_enable(en[3]), .spi_sclk(sclk[3]), .spi_cs_n(cs_n[3]),
        .spi_mosi(mosi[3]), .rx_data(rxd[3]), .rx_data_valid(vld[3]),
        .frame_abort(abt[3]), .cs_active(csa[3]), .bit_count(bc[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input int i, input logic a, input logic [31:0] d);
        exp_t e;
        e.idx   = 2'(i);
        e.abort = a;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Pops one expectation per strobe seen on any instance.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (vld[i] || abt[i]) begin
                        chk($sformatf("excl_inst%0d", i), {31'd0, vld[i] && abt[i]}, 32'd0);
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_strobe inst%0d: got valid=%0b abort=%0b data=%h, expected no strobe",
                                     i, vld[i], abt[i], rxd[i]);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("strobe_inst%0d", i), 32'(i), 32'(e.idx));
                            chk($sformatf("abort_flag_inst%0d", i), {31'd0, abt[i]}, {31'd0, e.abort});
                            if (!e.abort) chk($sformatf("rx_data_inst%0d", i), rxd[i], e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // Master drives n bits of w; optionally raises CS_N with the final sampling edge.
    task automatic spi_bits(input int i, input logic [31:0] w, input int n,
                            input bit msb_order, input bit cs_on_last);
        logic bv;
        for (int b = 0; b < n; b++) begin
            bv = msb_order ? w[31-b] : w[b];
            if (cpha_c[i] == 0) begin
                mosi[i] = bv;
                half();
                sclk[i] = ~sclk[i];
                if (cs_on_last && b == n - 1) cs_n[i] = 1'b1;
                half();
                sclk[i] = ~sclk[i];
            end else begin
                sclk[i] = ~sclk[i];
                mosi[i] = bv;
                half();
                sclk[i] = ~sclk[i];
                if (cs_on_last && b == n - 1) cs_n[i] = 1'b1;
                half();
            end
        end
    endtask

    task automatic cs_low(input int i);
        cs_n[i] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high(input int i);
        repeat (4) @(negedge clk);
        cs_n[i] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, "_rx_data"}, rxd[i], 32'd0);
        chk({tag, "_valid"}, {31'd0, vld[i]}, 32'd0);
        chk({tag, "_abort"}, {31'd0, abt[i]}, 32'd0);
        chk({tag, "_cs_active"}, {31'd0, csa[i]}, 32'd0);
        chk({tag, "_bit_count"}, {27'd0, bc[i]}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sclk[i] = 1'(cpol_c[i]);
            cs_n[i] = 1'b1;
            mosi[i] = 1'b0;
            en[i]   = 1'b1;
        end
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        chk_zero("reset", 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single sync word in mode 0.
        cs_low(0);
        chk("cs_active_low", {31'd0, csa[0]}, 32'd1);
        push(0, 1'b0, 32'h55AA55AA);
        spi_bits(0, 32'h55AA55AA, 32, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("sync_word", rxd[0], 32'h55AA55AA);
        chk("bit_count_wrap", {27'd0, bc[0]}, 32'd0);
        cs_high(0);
        chk("cs_active_high", {31'd0, csa[0]}, 32'd0);

        // Three back-to-back words in one CS assertion.
        cs_low(0);
        push(0, 1'b0, 32'h00000001);
        push(0, 1'b0, 32'hDEADBEEF);
        push(0, 1'b0, 32'hFFFFFFFF);
        spi_bits(0, 32'h00000001, 32, 1'b1, 1'b0);
        spi_bits(0, 32'hDEADBEEF, 32, 1'b1, 1'b0);
        spi_bits(0, 32'hFFFFFFFF, 32, 1'b1, 1'b0);
        cs_high(0);

        // Truncated word after 13 bits, then a clean word.
        cs_low(0);
        spi_bits(0, 32'h0F0F0F0F, 13, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("partial_count", {27'd0, bc[0]}, 32'd13);
        push(0, 1'b1, 32'd0);
        cs_high(0);
        chk("abort_keeps_data", rxd[0], 32'hFFFFFFFF);
        cs_low(0);
        push(0, 1'b0, 32'h12345678);
        spi_bits(0, 32'h12345678, 32, 1'b1, 1'b0);
        cs_high(0);

        // Other SPI modes and LSB-first assembly.
        cs_low(1);
        push(1, 1'b0, 32'hA5A50F0F);
        spi_bits(1, 32'hA5A50F0F, 32, 1'b1, 1'b0);
        cs_high(1);
        cs_low(2);
        push(2, 1'b0, 32'hA5A50F0F);
        spi_bits(2, 32'hA5A50F0F, 32, 1'b1, 1'b0);
        cs_high(2);
        cs_low(3);
        push(3, 1'b0, 32'hF0F0A5A5);
        spi_bits(3, 32'hA5A50F0F, 32, 1'b1, 1'b0);
        push(3, 1'b0, 32'hA5A50F0F);
        spi_bits(3, 32'hA5A50F0F, 32, 1'b0, 1'b0);
        cs_high(3);

        // Reset at bit 20, then rx_enable dropped mid-word.
        cs_low(0);
        spi_bits(0, 32'h0, 20, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midword_reset", 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(0, 32'hFFFFFFFF, 10, 1'b1, 1'b0);
        en[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("disable_clears_count", {27'd0, bc[0]}, 32'd0);
        spi_bits(0, 32'hFFFFFFFF, 5, 1'b1, 1'b0);
        en[0] = 1'b1;
        repeat (4) @(negedge clk);
        push(0, 1'b0, 32'hCAFEF00D);
        spi_bits(0, 32'hCAFEF00D, 32, 1'b1, 1'b0);
        cs_high(0);

        // Final sampling edge coincides with CS_N rising.
        cs_low(0);
        push(0, 1'b0, 32'h0BADF00D);
        spi_bits(0, 32'h0BADF00D, 32, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("same_cycle_data", rxd[0], 32'h0BADF00D);
        chk("same_cycle_cs", {31'd0, csa[0]}, 32'd0);

        // Drain: every expected strobe must have appeared.
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
